// File: rtl/frame_sweeper.sv
// frame_sweeper: row-major scan sequencer feeding the scenery lookups and
// driving the VGA write port one pixel per cycle. Coordinates are delayed
// through a LATENCY-deep {x, y, valid} line so each returning colour is
// paired with the coordinate that produced it.
module frame_sweeper #(
    parameter int unsigned WIDTH   = 320,
    parameter int unsigned HEIGHT  = 256,
    parameter int unsigned LATENCY = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] colour_in,
    output logic [8:0] x_cord,
    output logic [8:0] y_cord,
    output logic [8:0] vga_x,
    output logic [8:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic [7:0] frame_count
);

    localparam logic [8:0] XMAX = 9'(WIDTH - 1);
    localparam logic [8:0] YMAX = 9'(HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                      state_q, state_d;
    logic   [8:0]                x_q, x_d;
    logic   [8:0]                y_q, y_d;
    logic   [LATENCY-1:0][8:0]   dx_q, dx_d;
    logic   [LATENCY-1:0][8:0]   dy_q, dy_d;
    logic   [LATENCY-1:0]        dv_q, dv_d;
    logic   [8:0]                vga_x_q, vga_x_d;
    logic   [8:0]                vga_y_q, vga_y_d;
    logic   [2:0]                vga_colour_q, vga_colour_d;
    logic                        plot_q, plot_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic   [7:0]                fc_q, fc_d;

    // Next-state, coordinate stepping, delay-line shift and output staging.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        done_d       = 1'b0;
        fc_d         = fc_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SWEEP;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            S_SWEEP: begin
                if (x_q == XMAX) begin
                    if (y_q == YMAX) begin
                        state_d = S_DRAIN;
                    end else begin
                        x_d = '0;
                        y_d = y_q + 9'd1;
                    end
                end else begin
                    x_d = x_q + 9'd1;
                end
            end
            S_DRAIN: begin
                if (dv_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    fc_d    = fc_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);

        dx_d[0] = x_q;
        dy_d[0] = y_q;
        dv_d[0] = (state_q == S_SWEEP);
        for (int unsigned i = 1; i < LATENCY; i++) begin
            dx_d[i] = dx_q[i-1];
            dy_d[i] = dy_q[i-1];
            dv_d[i] = dv_q[i-1];
        end

        plot_d = dv_q[LATENCY-1];
        if (dv_q[LATENCY-1]) begin
            vga_x_d      = dx_q[LATENCY-1];
            vga_y_d      = dy_q[LATENCY-1];
            vga_colour_d = colour_in;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            dv_q         <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fc_q         <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            dv_q         <= dv_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            plot_q       <= plot_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fc_q         <= fc_d;
        end
    end

    assign x_cord      = x_q;
    assign y_cord      = y_q;
    assign vga_x       = vga_x_q;
    assign vga_y       = vga_y_q;
    assign vga_colour  = vga_colour_q;
    assign plot        = plot_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign frame_count = fc_q;

endmodule

// File: doc/frame_sweeper.md
Name: frame_sweeper

Overview:
- Scan sequencer that sits directly upstream of the per-pixel scenery lookups (trap and lava colour generators).
- Sweeps x_cord/y_cord row-major over the play field and feeds them to the lookups.
- Realigns the registered colour that comes back with the coordinate that produced it.
- Drives the VGA adapter's plot/x/y/colour write port, one pixel per cycle, with a start/busy/done handshake to the game controller.

Parameters:
- WIDTH, 320, pixels per row; 1..512.
- HEIGHT, 256, rows per frame; 1..512.
- LATENCY, 1, clock cycles from x_cord/y_cord to a valid colour_in; 1..4.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high.
- start  input  1  request one full-frame sweep; sampled only in IDLE.
- colour_in  input  3  colour from the lookup stage; valid LATENCY cycles after the coordinate.
- x_cord  output  9  column presented to the lookups.
- y_cord  output  9  row presented to the lookups.
- vga_x  output  9  column of the pixel being plotted.
- vga_y  output  9  row of the pixel being plotted.
- vga_colour  output  3  colour of the pixel being plotted.
- plot  output  1  VGA write strobe.
- busy  output  1  frame sweep in progress.
- done  output  1  one-cycle pulse at frame end.
- frame_count  output  8  completed frames; wraps 255 -> 0.

Behaviour:
- Reset: all outputs 0, state IDLE, valid pipeline cleared. Reset wins over every other event, including mid-sweep; the aborted frame does not count.
- All outputs are registered.
- States:
  - IDLE: start=1 at a posedge -> SWEEP. start is ignored in every other state.
  - SWEEP: each cycle presents one pixel k on x_cord/y_cord, k = 0..N-1, N = WIDTH*HEIGHT, starting at (0,0).
    - x increments each cycle.
    - At x = WIDTH-1, x wraps to 0 and y increments.
    - After (WIDTH-1, HEIGHT-1) is presented -> DRAIN. x_cord/y_cord then hold (WIDTH-1, HEIGHT-1).
  - DRAIN: waits until the coordinate/valid delay line is empty, then -> DONE.
  - DONE: done=1 for exactly one cycle, frame_count increments, then -> IDLE.
- Timing, with the cycle in which start is sampled high counted as cycle 0:
  - pixel k is presented in cycle 1+k;
  - colour_in for pixel k is captured at the end of cycle 1+k+LATENCY;
  - plot=1 with vga_x/vga_y = pixel k and vga_colour = that captured colour_in in cycle 2+k+LATENCY.
- Delay line: LATENCY stages of {x, y, valid}. valid is set only for SWEEP cycles. plot equals the registered valid at stage LATENCY.
- Plot strobe: plot is high for exactly N cycles per frame, contiguous, no gaps, no duplicates. plot is 0 in IDLE, in DONE, and after reset.
- vga_x/vga_y/vga_colour hold their last values while plot=0.
- busy: 1 from cycle 1 through the done cycle inclusive; 0 otherwise.
- Back-to-back frames: with start held high, the next frame is accepted in the IDLE cycle after DONE. There is a one-cycle gap, and no overlap.
- No stall input. The lookups are free-running, so the sweep never pauses once started.
- Counter widths:
  - x/y counters are 9 bits and compare against WIDTH-1 / HEIGHT-1; values ≥ WIDTH or ≥ HEIGHT never appear.
  - WIDTH=1 or HEIGHT=1 must work. With WIDTH=1, y increments every cycle.

Test Plan:
- Reset values: assert reset 3 cycles with start=1 -> all outputs 0. Release reset with start=0 -> outputs stay 0, busy=0.
- Full frame (WIDTH=4, HEIGHT=3, LATENCY=1; bench model registers colour = x[0] ? 3'b100 : 3'b000). Pulse start in cycle 0 ->
  - x_cord/y_cord (0,0) in cycle 1, (3,2) in cycle 12;
  - plot high in cycles 3..14 with (0,0,000),(1,0,100),...,(3,2,100) in order;
  - done in cycle 15; busy cycles 1..15; frame_count=1.
- Start while busy: same config, additional start pulses in cycles 5 and 15 -> identical 12-plot sequence, single done at cycle 15, frame_count=1, no second frame.
- Reset mid-frame: reset in cycle 6 (pixel (1,1) being presented) ->
  - cycle 7: all outputs 0, busy=0, no further plot;
  - a new start then restarts at (0,0) with the full 12-plot sequence; frame_count ends at 1.
- LATENCY=2 (two-stage bench colour model, colour = {y[0], x[1:0]}), WIDTH=4, HEIGHT=3 -> plot in cycles 4..15, each vga_colour matching its vga_x/vga_y; done in cycle 16.
- Continuous start and wrap: start held high, WIDTH=2, HEIGHT=1 ->
  - frame period 6 cycles (plots 3..4, done 5, IDLE 6, next coords from 7);
  - after 256 done pulses frame_count wraps to 0.
